// File: rtl/ifra_slv_buf.sv
// ifra_slv_buf: ifra slave front end with a show-ahead receive FIFO.
//
// Words arrive from an ifra master over req/ack. Each transfer waits ack_dly
// extra cycles (sampled when the transfer starts) before a one-cycle ack pulse.
// The word is pushed into a DEPTH-entry FIFO on the ack cycle. The FIFO drains
// through a valid/ready stream port. While the FIFO is full, no new transfer
// starts, so ack is withheld as backpressure.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   req, din          master request and write data (din valid while req=1)
//   ack               registered one-cycle accept pulse
//   ack_dly           extra wait cycles before ack, latched at transfer start
//   m_valid, m_data   FIFO head (show-ahead); m_data reads 0 while empty
//   m_ready           downstream pop strobe (ignored while empty)
//   count, full, empty  registered FIFO occupancy flags
//
// Optional build macro IFRA_SLV_BUF_STATS_EN adds two ports:
//   rcv_cnt           wrapping count of accepted words
//   busy_cyc          saturating count of IDLE cycles with req=1 and full=1
module ifra_slv_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int DLY_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [DW-1:0]              din,
  output logic                       ack,
  input  logic [DLY_W-1:0]           ack_dly,
  output logic                       m_valid,
  output logic [DW-1:0]              m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef IFRA_SLV_BUF_STATS_EN
  ,
  output logic [31:0]                rcv_cnt,
  output logic [31:0]                busy_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t           state;
  logic [DLY_W-1:0] dcnt;

  // Handshake FSM. ack is registered and is high exactly while in ACK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          // Only one transfer is in flight, so a free slot here is still
          // free when the push happens.
          if (req && !full) begin
            if (ack_dly == '0) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              dcnt  <= ack_dly;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A dropped req abandons the transfer, even on the last wait cycle.
          if (!req) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == DLY_W'(1)) begin
            state <= ACK;
            ack   <= 1'b1;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt - DLY_W'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [CW-1:0] cnt_nxt;

  assign push    = ack;
  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    cnt_nxt = count + CW'(push) - CW'(pop);
  end

  // Storage has no reset; empty gates m_data, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

`ifdef IFRA_SLV_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcv_cnt  <= '0;
      busy_cyc <= '0;
    end else begin
      if (state == ACK) rcv_cnt <= rcv_cnt + 32'd1;
      if (state == IDLE && req && full && busy_cyc != '1)
        busy_cyc <= busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifra_slv_buf.sv
// Bench for ifra_slv_buf. A transfer-level model predicts ack timing from the
// cycle in which req is first seen idle (ack at t+1+D). It keeps the FIFO
// contents as a queue of acked words. The model is checked against the DUT
// every cycle, and directed steps add explicit latency and occupancy checks.
module tb_ifra_slv_buf;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DLY_W = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [DW-1:0]    din = '0;
  logic             ack;
  logic [DLY_W-1:0] ack_dly = '0;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic             m_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             full, empty;
`ifdef IFRA_SLV_BUF_STATS_EN
  logic [31:0]      rcv_cnt, busy_cyc;
`endif

  always #5 clk = ~clk;

  ifra_slv_buf #(.DW(DW), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack),
    .ack_dly(ack_dly), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .count(count), .full(full), .empty(empty)
`ifdef IFRA_SLV_BUF_STATS_EN
    , .rcv_cnt(rcv_cnt), .busy_cyc(busy_cyc)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DW-1:0] q[$];
  bit            pend;
  longint        start_c, ack_c, cyc;
  logic [31:0]   m_rcv, m_busy;
  bit            armed, auto_pop, rnd_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, advance the model across the
  // edge, then land #1 after the edge.
  task automatic tick();
    bit            e_ack, idle;
    int            sz;
    logic [DW-1:0] e_data;
    e_ack = pend && (ack_c == cyc);
    if (auto_pop)  m_ready = e_ack;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    sz = q.size();
    if (armed) begin
      e_data = (sz > 0) ? q[0] : '0;
      chk("ack",     32'(ack),     32'(e_ack));
      chk("count",   32'(count),   32'(sz));
      chk("empty",   32'(empty),   32'(sz == 0));
      chk("full",    32'(full),    32'(sz == DEPTH));
      chk("m_valid", 32'(m_valid), 32'(sz > 0));
      chk("m_data",  32'(m_data),  32'(e_data));
`ifdef IFRA_SLV_BUF_STATS_EN
      chk("rcv_cnt",  rcv_cnt,  m_rcv);
      chk("busy_cyc", busy_cyc, m_busy);
`endif
    end
    if (!rst_n) begin
      q.delete(); pend = 0; m_rcv = '0; m_busy = '0; armed = 1;
    end else begin
      idle = !pend;
      if (idle && req && sz == DEPTH && m_busy != 32'hFFFF_FFFF) m_busy++;
      if (e_ack) m_rcv++;
      if (pend && cyc > start_c && cyc < ack_c && !req) pend = 0;
      if (idle && req && sz < DEPTH) begin
        pend = 1; start_c = cyc; ack_c = cyc + 1 + longint'(ack_dly);
      end
      if (sz > 0 && m_ready) void'(q.pop_front());
      if (e_ack) begin q.push_back(din); pend = 0; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Master: hold req/din until ack is seen; n = cycles spent including ack.
  task automatic send(input logic [DW-1:0] w, input int d, output int n);
    bit got;
    req = 1'b1; din = w; ack_dly = DLY_W'(d);
    n = 0; got = 0;
    do begin got = ack; tick(); n++; end while (!got && n < 300);
    chk("send_done", 32'(got), 32'd1);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int k = 0; k < 64 && q.size() > 0; k++) tick();
    chk("drain", 32'(count), 32'd0);
  endtask

  initial begin
    int n;
    logic [DW-1:0] w;
    int d;
    cyc = 0; pend = 0; armed = 0; auto_pop = 0; rnd_ready = 0;
    m_rcv = '0; m_busy = '0;

    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    chk("rst_ack",     32'(ack),     32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);

    // back-to-back, zero delay, streaming out
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i), 0, n);
      chk("t1_lat", 32'(n), 32'd2);
      chk("t1_cnt_le1", 32'(count <= 1), 32'd1);
    end
    req = 1'b0; repeat (3) tick();

    // delay 5, single word
    m_ready = 1'b0;
    send(8'hA5, 5, n);
    chk("t2_lat", 32'(n), 32'd7);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_data", 32'(m_data), 32'hA5);
    req = 1'b0;
    chk("t2_pulse", 32'(ack), 32'd0);
    tick();
    drain();

    // fill to full, backpressure, single pop, then finish 20 words
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom_range(0, 3);
      send(DW'($urandom), d, n);
      chk("t3_lat", 32'(n), 32'(d + 2));
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'(DEPTH));
    w = DW'($urandom); d = $urandom_range(0, 3);
    req = 1'b1; din = w; ack_dly = DLY_W'(d);
    repeat (4) begin tick(); chk("t3_hold", 32'(ack), 32'd0); end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t3_pop", 32'(count), 32'(DEPTH - 1));
    send(w, d, n);
    chk("t3_lat17", 32'(n), 32'(d + 2));
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(DW'($urandom), $urandom_range(0, 3), n);
    req = 1'b0;
    drain();

    // steady occupancy 3 with simultaneous push/pop across pointer wrap
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(DW'($urandom), 0, n);
    auto_pop = 1;
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 2);
      send(DW'($urandom), d, n);
      chk("t4_lat", 32'(n), 32'(d + 2));
      chk("t4_cnt", 32'(count), 32'd3);
    end
    auto_pop = 0; req = 1'b0;
    drain();

    // abort in WAIT, then prove the FSM is idle again
    m_ready = 1'b0;
    req = 1'b1; din = 8'h3C; ack_dly = 4'd7;
    tick(); tick(); tick();
    req = 1'b0; tick();
    chk("t5_abort_ack", 32'(ack), 32'd0);
    chk("t5_abort_cnt", 32'(count), 32'd0);
    send(8'h5A, 0, n);
    chk("t5_idle_lat", 32'(n), 32'd2);
    req = 1'b0; tick();

    // reset during WAIT with 5 words stored
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1, n);
    chk("t5_five", 32'(count), 32'd5);
    req = 1'b1; din = 8'hEE; ack_dly = 4'd7;
    tick(); tick();
    rst_n = 1'b0; req = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_cnt", 32'(count), 32'd0);
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
`ifdef IFRA_SLV_BUF_STATS_EN
    chk("t6_rst_rcv", rcv_cnt, 32'd0);
    chk("t6_rst_busy", busy_cyc, 32'd0);
    for (int i = 0; i < 10; i++) send(DW'($urandom), 0, n);
    req = 1'b0; tick();
    chk("t6_rcv10", rcv_cnt, 32'd10);
`endif
    repeat (10) tick();

    // random traffic with random downstream readiness
    rnd_ready = 1;
    for (int i = 0; i < 30; i++) begin
      send(DW'($urandom), $urandom_range(0, 3), n);
      if ($urandom_range(0, 1) == 1) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    rnd_ready = 0; req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
